// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer.
// Holds the mode encodings, the issuer state type and the default operand width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    typedef logic [1:0] alu_mode_t;

    localparam alu_mode_t MODE_MUL   = 2'd0;
    localparam alu_mode_t MODE_DIV   = 2'd1;
    localparam alu_mode_t MODE_SHIFT = 2'd2;
    localparam alu_mode_t MODE_AVG   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer_wdt.sv
// Wait-cycle watchdog for the issuer: cleared on entry to WAIT, counts while enabled,
// and flags expiry when the count reaches TIMEOUT-1.
module issuer_wdt #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_reg;

    // Holds at the terminal value so the counter can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Single-outstanding command initiator for the 4-mode ALU: accepts a command, pulses it
// into the ALU, waits (bounded) for the answer and presents it downstream with tag and error.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic                alu_valid,
    output logic [1:0]          alu_mode,
    output logic [DATA_W-1:0]   alu_in_a,
    output logic [DATA_W-1:0]   alu_in_b,
    input  logic                alu_ready,
    input  logic [2*DATA_W-1:0] alu_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]    res_tag,
    output logic                res_err
);

    issuer_state_t state_reg, state_next;

    alu_mode_t           mode_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [2*DATA_W-1:0] res_data_reg;
    logic                res_err_reg;

    logic wdt_clear;
    logic wdt_enable;
    logic wdt_expired;

    issuer_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A ready that coincides with expiry is treated as a normal completion.
    always_comb begin
        state_next = state_reg;
        wdt_clear  = 1'b0;
        wdt_enable = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdt_clear  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_ready || wdt_expired) begin
                    state_next = ST_HOLD;
                end else begin
                    wdt_enable = 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= MODE_MUL;
            a_reg        <= '0;
            b_reg        <= '0;
            tag_reg      <= '0;
            res_data_reg <= '0;
            res_err_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && cmd_valid) begin
                mode_reg <= cmd_mode;
                a_reg    <= cmd_a;
                b_reg    <= cmd_b;
                tag_reg  <= cmd_tag;
            end
            if (state_reg == ST_WAIT) begin
                if (alu_ready) begin
                    res_data_reg <= alu_out;
                    res_err_reg  <= 1'b0;
                end else if (wdt_expired) begin
                    res_data_reg <= '0;
                    res_err_reg  <= 1'b1;
                end
            end
        end
    end

    // Every output is a function of registered state only.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign alu_valid = (state_reg == ST_ISSUE);
    assign alu_mode  = (state_reg == ST_ISSUE) ? mode_reg : 2'd0;
    assign alu_in_a  = (state_reg == ST_ISSUE) ? a_reg : '0;
    assign alu_in_b  = (state_reg == ST_ISSUE) ? b_reg : '0;
    assign res_valid = (state_reg == ST_HOLD);
    assign res_data  = res_data_reg;
    assign res_tag   = tag_reg;
    assign res_err   = res_err_reg;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, hand-written corner
// sequences and random commands checked against a behavioural ALU/issuer model.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DW      = 32;
    localparam int TW      = 4;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = 2'd0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          alu_valid;
    logic [1:0]    alu_mode;
    logic [DW-1:0] alu_in_a;
    logic [DW-1:0] alu_in_b;
    logic          alu_ready;
    logic [2*DW-1:0] alu_out = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [2*DW-1:0] res_data;
    logic [TW-1:0] res_tag;
    logic          res_err;

    alu_cmd_issuer #(.DATA_W(DW), .TAG_W(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_valid(alu_valid), .alu_mode(alu_mode), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_ready(alu_ready), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] alu_ref(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (m)
            MODE_MUL:   return 64'(a) * 64'(b);
            MODE_DIV:   return (b == 0) ? '1 : {a % b, a / b};
            MODE_SHIFT: return 64'(a >> sh);
            default:    return 64'((33'(a) + 33'(b)) >> 1);
        endcase
    endfunction

    // ALU model: ready for one cycle, alu_delay cycles after the valid cycle.
    logic model_rdy = 1'b0;
    logic man_rdy   = 1'b0;
    int   pend      = 0;
    int   alu_delay = 1;
    bit   alu_mute  = 1'b0;
    logic [1:0]  pm = 2'd0;
    logic [31:0] pa = '0, pb = '0;
    assign alu_ready = model_rdy | man_rdy;

    always @(negedge clk) begin
        model_rdy = 1'b0;
        if (alu_valid) begin
            pend = alu_mute ? 0 : alu_delay;
            pm = alu_mode; pa = alu_in_a; pb = alu_in_b;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                model_rdy = 1'b1;
                alu_out   = alu_ref(pm, pa, pb);
            end
        end
    end

    // Full transaction; expected latency counted in edges from the accepting edge.
    task automatic run_cmd(input string name, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag, input int delay,
                           input bit mute, input logic [63:0] exp_data, input bit exp_err);
        int guard;
        int edges;
        int exp_lat;
        bit ready_seen;
        logic [63:0] got;
        alu_delay = delay; alu_mute = mute;
        cmd_valid = 1'b1; cmd_mode = m; cmd_a = a; cmd_b = b; cmd_tag = tag;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin tick(); guard++; end
        chk({name, " accept"}, 64'(guard < 200), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk({name, " issue valid"}, 64'(alu_valid), 64'd1);
        chk({name, " issue mode"}, 64'(alu_mode), 64'(m));
        chk({name, " issue a"}, 64'(alu_in_a), 64'(a));
        chk({name, " issue b"}, 64'(alu_in_b), 64'(b));
        tick();
        edges = 1;
        chk({name, " single pulse"}, 64'(alu_valid), 64'd0);
        ready_seen = 1'b0;
        while (res_valid !== 1'b1 && edges < TIMEOUT + 20) begin
            if (cmd_ready) ready_seen = 1'b1;
            tick(); edges++;
        end
        exp_lat = exp_err ? TIMEOUT + 1 : delay + 1;
        chk({name, " res_valid"}, 64'(res_valid), 64'd1);
        chk({name, " latency"}, 64'(edges), 64'(exp_lat));
        chk({name, " data"}, res_data, exp_data);
        chk({name, " tag"}, 64'(res_tag), 64'(tag));
        chk({name, " err"}, 64'(res_err), 64'(exp_err));
        chk({name, " busy"}, 64'(ready_seen | cmd_ready), 64'd0);
        got = res_data;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, " released"}, 64'(res_valid), 64'd0);
        chk({name, " ready again"}, 64'(cmd_ready), 64'd1);
        $display("txn %s mode=%0d a=%h b=%h tag=%0d delay=%0d -> data=%h err=%0b lat=%0d",
                 name, m, a, b, tag, delay, got, exp_err, edges);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        int          delay;
        bit          mute;
        logic [63:0] data;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int guard;
        bit flag;
        logic [1:0]  rm;
        logic [31:0] ra, rb;
        logic [3:0]  rt;
        int rd;
        bit re;

        vecs[0] = '{MODE_MUL,   32'd3,          32'd5,          4'd7,  32,          1'b0, 64'h0F, 1'b0};
        vecs[1] = '{MODE_DIV,   32'd100,        32'd7,          4'd2,  32,          1'b0, 64'h00000002_0000000E, 1'b0};
        vecs[2] = '{MODE_SHIFT, 32'hF0,         32'd3,          4'd3,  1,           1'b0, 64'h1E, 1'b0};
        vecs[3] = '{MODE_AVG,   32'hFFFFFFFF,   32'd1,          4'd4,  1,           1'b0, 64'h80000000, 1'b0};
        vecs[4] = '{MODE_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   4'd5,  20,          1'b0, 64'hFFFFFFFE_00000001, 1'b0};
        vecs[5] = '{MODE_DIV,   32'd7,          32'd100,        4'd6,  TIMEOUT,     1'b0, 64'h00000007_00000000, 1'b0};
        vecs[6] = '{MODE_AVG,   32'd10,         32'd20,         4'd8,  TIMEOUT + 1, 1'b0, 64'h0, 1'b1};
        vecs[7] = '{MODE_SHIFT, 32'd1,          32'd0,          4'hF,  1,           1'b1, 64'h0, 1'b1};

        // Reset values
        repeat (2) tick();
        chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst alu_valid", 64'(alu_valid), 64'd0);
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst res_data", res_data, 64'd0);
        chk("rst res_tag", 64'(res_tag), 64'd0);
        chk("rst res_err", 64'(res_err), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].tag,
                    vecs[i].delay, vecs[i].mute, vecs[i].data, vecs[i].err);
        end

        // Back-to-back shift then avg with res_ready tied high
        res_ready = 1'b1; alu_delay = 1; alu_mute = 1'b0;
        cmd_valid = 1'b1; cmd_mode = MODE_SHIFT; cmd_a = 32'hF0; cmd_b = 32'd3; cmd_tag = 4'd1;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 60) begin tick(); guard++; end
        chk("b2b shift data", res_data, 64'h1E);
        cmd_valid = 1'b1; cmd_mode = MODE_AVG; cmd_a = 32'hFFFFFFFF; cmd_b = 32'd1; cmd_tag = 4'd2;
        chk("b2b no accept in hold", 64'(cmd_ready), 64'd0);
        tick();
        chk("b2b idle after handshake", 64'({cmd_ready, alu_valid, res_valid}), 64'b100);
        tick();
        chk("b2b second issue", 64'({alu_valid, alu_in_a}), {31'd0, 1'b1, 32'hFFFFFFFF});
        cmd_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 60) begin tick(); guard++; end
        chk("b2b avg data", res_data, 64'h80000000);
        chk("b2b avg tag", 64'(res_tag), 64'd2);
        tick();
        res_ready = 1'b0;
        $display("txn b2b shift/avg done");

        // Backpressure in HOLD
        alu_delay = 3;
        cmd_valid = 1'b1; cmd_mode = MODE_MUL; cmd_a = 32'd6; cmd_b = 32'd7; cmd_tag = 4'hA;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 60) begin tick(); guard++; end
        cmd_valid = 1'b1; cmd_mode = MODE_SHIFT; cmd_a = 32'd8; cmd_b = 32'd1; cmd_tag = 4'hB;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp hold %0d", i), {res_valid, cmd_ready, res_tag, res_data[57:0]},
                {1'b1, 1'b0, 4'hA, 58'd42});
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp ready after handshake", 64'({cmd_ready, alu_valid}), 64'b10);
        tick();
        chk("bp next issue", 64'({alu_valid, alu_in_a}), {31'd0, 1'b1, 32'd8});
        cmd_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 60) begin tick(); guard++; end
        chk("bp next data", res_data, 64'd4);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        $display("txn backpressure done");

        // Timeout, then late alu_ready pulses are ignored
        alu_mute = 1'b1;
        cmd_valid = 1'b1; cmd_mode = MODE_DIV; cmd_a = 32'd50; cmd_b = 32'd5; cmd_tag = 4'hC;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < TIMEOUT + 20) begin tick(); guard++; end
        chk("to latency", 64'(guard), 64'(TIMEOUT + 1));
        chk("to err/data", {res_err, res_data[62:0]}, 64'h8000000000000000);
        repeat (4) tick();
        man_rdy = 1'b1; tick(); man_rdy = 1'b0;
        chk("to late pulse in hold", {res_valid, res_err, res_data[61:0]}, 64'hC000000000000000);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        man_rdy = 1'b1; tick(); man_rdy = 1'b0;
        chk("to late pulse in idle", 64'({res_valid, cmd_ready}), 64'b01);
        alu_mute = 1'b0;
        run_cmd("after_to", MODE_DIV, 32'd50, 32'd5, 4'hD, 32, 1'b0, 64'h00000000_0000000A, 1'b0);

        // Reset in WAIT cycle 10 with the ALU answer still pending
        alu_delay = 32;
        cmd_valid = 1'b1; cmd_mode = MODE_MUL; cmd_a = 32'd9; cmd_b = 32'd9; cmd_tag = 4'h5;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("rst mid cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst mid outputs", {alu_valid, res_valid, res_err, res_tag, alu_mode, alu_in_a},
            64'd0);
        chk("rst mid res_data", res_data, 64'd0);
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid || !cmd_ready) flag = 1'b1;
            tick();
        end
        chk("rst stale ready ignored", 64'(flag), 64'd0);
        $display("txn reset mid-wait done");

        // Random commands against the reference model
        for (int i = 0; i < 25; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (rm == MODE_DIV) ? 32'($urandom_range(1, 1000)) : $urandom;
            rt = 4'($urandom);
            rd = $urandom_range(1, TIMEOUT + 3);
            re = (rd > TIMEOUT);
            run_cmd($sformatf("rnd%0d", i), rm, ra, rb, rt, rd, 1'b0,
                    re ? 64'd0 : alu_ref(rm, ra, rb), re);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Hardware initiator for the 4-mode ALU's valid/ready interface: mul, div, shift, avg.
- Accepts operation commands from an upstream producer over a valid/ready handshake.
- Issues each command to the ALU as a single-cycle valid pulse and waits for the ALU ready.
- Captures the 64-bit ALU result and returns it downstream with a tag and an error flag; one command is in flight at a time.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- TAG_W, 4, width of the command tag passed through to the result.
- TIMEOUT, 40, maximum WAIT cycles before the command is aborted. Must be >= 34 so it covers the 32-cycle mul/div.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_mode  in  2  0 mul, 1 div, 2 shift, 3 avg
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_tag  in  TAG_W  user tag
- alu_valid  out  1  one-cycle issue pulse to ALU
- alu_mode  out  2  mode to ALU
- alu_in_a  out  DATA_W  operand A to ALU
- alu_in_b  out  DATA_W  operand B to ALU
- alu_ready  in  1  ALU result valid
- alu_out  in  2*DATA_W  ALU result; for div, {remainder, quotient}
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  2*DATA_W  captured result
- res_tag  out  TAG_W  tag of the completed command
- res_err  out  1  1 = timeout abort, res_data = 0

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs are 0 except cmd_ready, which is 1 since it is decoded from IDLE. Operand, tag and result registers clear to 0; the wait counter clears to 0.
- The state machine has four states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, register mode, a, b and tag, then go to ISSUE.
  - alu_valid = 0; alu_mode, alu_in_a and alu_in_b are driven 0 outside ISSUE.
- ISSUE (exactly one cycle):
  - alu_valid = 1, with the registered mode and operands driven on alu_mode, alu_in_a and alu_in_b.
  - alu_ready is ignored in this cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - If alu_ready is high, capture alu_out into res_data, set res_err = 0, and go to HOLD.
  - Otherwise, if wait_cnt == TIMEOUT-1, set res_data = 0 and res_err = 1, and go to HOLD.
  - Otherwise increment wait_cnt.
  - If alu_ready and the timeout occur in the same cycle, alu_ready wins.
- HOLD:
  - res_valid = 1; res_data, res_tag and res_err are held stable.
  - On res_ready, go to IDLE.
  - No new command is accepted in the same cycle: cmd_ready goes high on the following cycle.
- Latency:
  - Command accepted at edge N: alu_valid is high during cycle N+1, and WAIT begins at cycle N+2.
  - If alu_ready is first high in WAIT cycle k, res_valid rises on the next cycle.
  - A shift/avg ALU that answers one cycle after its valid gives res_valid 3 cycles after command accept.
- alu_ready seen in IDLE, HOLD or ISSUE is ignored; this covers late responses after a timeout.
- Outputs are registered or decoded from the state only; there are no combinational paths from inputs to outputs.
- The wait counter is $clog2(TIMEOUT) bits wide and never wraps, because it is reset on entry to WAIT.
- Reset asserted mid-operation returns the block immediately to the reset values and discards the in-flight command.

Decomposition:
- Shared package alu_pkg holds:
  - mode constants MODE_MUL=0, MODE_DIV=1, MODE_SHIFT=2, MODE_AVG=3;
  - a 2-bit alu_mode_t typedef;
  - the state enum issuer_state_t;
  - the DATA_W default.
- One natural sub-module, issuer_wdt: a loadable wait counter with clear, enable and expired (== TIMEOUT-1) outputs. Everything else lives in the top level.

Test Plan:
- Mul: cmd_mode=0, a=3, b=5, tag=7; the ALU model asserts ready 32 cycles after alu_valid -> alu_valid high for exactly 1 cycle; res_valid with res_data=64'h0F, res_tag=7, res_err=0.
- Div: a=100, b=7 -> res_data=64'h00000002_0000000E ({R, Q}); cmd_ready stays low from accept until the result is consumed.
- Shift then avg, back-to-back with res_ready tied high:
  - shift a=32'hF0, b=3 -> res_data=64'h1E;
  - avg a=32'hFFFFFFFF, b=1 -> res_data=64'h80000000;
  - second accept occurs the cycle after the first result handshake.
- Timeout: the ALU model never asserts ready -> res_valid rises TIMEOUT+1 cycles after alu_valid, with res_err=1 and res_data=0. An alu_ready pulse 5 cycles later is ignored and the next command completes normally.
- Backpressure: res_ready held low for 6 cycles in HOLD -> res_valid, res_data and res_tag are stable; cmd_valid remains unaccepted until one cycle after the handshake.
- Reset mid-WAIT: rst_n pulsed low at WAIT cycle 10 -> all outputs go to reset values at once and cmd_ready=1 after release; a stale alu_ready produces no res_valid.
